soc_mem_io: RTL and testbench
=============================

# soc_mem_io

Memory and I/O slave that sits directly downstream of the multi-cycle RV32I processor core and serves its single memory port. It holds the word-addressed RAM for instructions and data, and decodes an I/O page containing an LED register and a UART transmitter with a TX FIFO. It is the only consumer of the core's address, strobe, mask and write-data outputs, and the only producer of its read data.

## Interface
- RAM_WORDS, 1024: RAM depth in 32-bit words; power of two.
- INIT_FILE, "": hex image loaded into RAM at elaboration with $readmemh; no load when empty.
- LED_W, 8: LED register width, 1..32.
- CLKS_PER_BIT, 868: UART bit period in clocks, ≥2.
- UART_FIFO_DEPTH, 16: TX FIFO entries, power of two ≥2. Used only with SOC_UART_FIFO_EN.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- mem_addr_i  in  32  byte address from the core; bits [1:0] ignored.
- mem_rstrb_i  in  1  read strobe.
- mem_rdata_o  out  32  read data.
- mem_wmask_i  in  4  byte-lane write enables; any bit set means a write cycle.
- mem_wdata_i  in  32  write data, already lane-replicated by the core.
- leds_o  out  LED_W  LED register.
- uart_tx_o  out  1  serial output, 8N1, LSB first.

## Operation
- Decode:
  - mem_addr_i[31]=0 selects RAM. Word index is mem_addr_i[log2(RAM_WORDS)+1:2]; higher bits are ignored, so addresses alias.
  - mem_addr_i[31]=1 selects I/O, decoded on bits [3:2]:
    - 0: LED
    - 1: UART_DATA
    - 2: UART_STATUS
    - 3: reserved; reads 0, writes ignored.
- RAM read: mem_rdata_o is the combinational RAM word at the decoded index, independent of mem_rstrb_i. The core samples it in the same cycle.
- RAM write: each lane k with mem_wmask_i[k]=1 updates byte k at the clock edge. Other lanes are untouched. RAM contents are not affected by reset.
- LED:
  - Read returns {0, leds_o}.
  - Any write cycle (wmask≠0) loads mem_wdata_i[LED_W-1:0].
- UART_DATA:
  - Write with wmask[0]=1 enqueues mem_wdata_i[7:0].
  - If the buffer is full at that edge, the byte is dropped and sticky overflow is set.
  - Reads return 0.
- UART_STATUS read value:
  - bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow.
  - bits[15:8] occupancy count.
  - Other bits 0.
- Overflow is cleared at the edge ending a cycle with mem_rstrb_i=1 at the UART_STATUS address. An overflow set at that same edge takes priority.
- Full/empty are the registered state at the start of the cycle. A simultaneous enqueue and dequeue with the buffer full drops the enqueue. A simultaneous enqueue and dequeue with the buffer not full leaves the count unchanged.
- Transmitter FSM:
  - IDLE: uart_tx_o=1. If the buffer is non-empty, pop the head into the shift register and go to START.
  - START: uart_tx_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each, then STOP.
  - STOP: uart_tx_o=1 for CLKS_PER_BIT cycles. On the last cycle, pop and go to START if the buffer is non-empty, else go to IDLE.
- tx_busy = state≠IDLE.
- Reset values:
  - leds_o=0, uart_tx_o=1, FSM=IDLE.
  - Buffer empty, count 0, overflow 0, bit and baud counters 0.
  - Reset asserted mid-frame aborts the frame immediately (uart_tx_o=1 on the next cycle) and discards queued bytes.

## Timing
- Read latency 0: mem_rdata_o is valid in the cycle the address is presented.
- Write latency 1: the written data is visible to a read in the cycle after the write cycle.
- UART start latency: for a write in cycle t with the FSM IDLE and the buffer empty:
  - count=1 in cycle t+1.
  - uart_tx_o=0 from cycle t+2.
- Frame length is exactly 10×CLKS_PER_BIT cycles. Back-to-back frames have no idle gap.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps on the bit boundary. The bit counter wraps 7→0 on entry to STOP.

## Configuration
- SOC_UART_FIFO_EN defined: TX buffer is a circular FIFO of UART_FIFO_DEPTH entries with wrapping read/write pointers and count 0..UART_FIFO_DEPTH.
- SOC_UART_FIFO_EN undefined: buffer is a single holding register.
  - full = count=1.
  - A second write during an active frame is accepted only after the head has been popped into the shift register.
  - The STATUS bit and the count field keep the same format.

## Test plan
- Reset with rst_ni=0 for 2 cycles: leds_o=0, uart_tx_o=1, STATUS read = 0x0000_0002.
- RAM byte write: write addr 0x0000_0006, wmask 4'b0100, wdata 0x00AB_0000, then read 0x0000_0004: byte 2 = 0xAB, other bytes unchanged. A read of 0x0000_1004 with RAM_WORDS=1024 aliases to the same word.
- UART with CLKS_PER_BIT=4: write 0x55 in cycle t. uart_tx_o is low in t+2..t+5, then follows data bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles. tx_busy drops at t+42.
- FIFO (SOC_UART_FIFO_EN, depth 4): 6 consecutive writes during the first frame. The first byte is popped at t+1, so the FIFO reaches full on the 5th write and the 6th is dropped. STATUS shows full=1, overflow=1. A STATUS read clears overflow; the next read shows overflow=0.
- Macro undefined: two back-to-back writes. The 2nd is accepted only after the 1st is popped, and both frames are transmitted in order.
- Reset mid-frame (DATA bit 3): uart_tx_o=1 on the next cycle, STATUS = 0x0000_0002, and no further frame is transmitted.

Source files
------------

// File: rtl/soc_mem_io_if.sv
// Single memory port between the RV32I core (master) and soc_mem_io (slave).
interface soc_mem_io_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;

    modport master (output mem_addr, mem_rstrb, mem_wmask, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_rstrb, mem_wmask, mem_wdata, output mem_rdata);
endinterface

// File: rtl/soc_mem_io.sv
// RAM plus I/O page (LED register, 8N1 UART transmitter) behind the core's memory port.
// Define SOC_UART_FIFO_EN for a UART_FIFO_DEPTH-entry TX FIFO; otherwise a single holding register.
module soc_mem_io #(
    parameter int    RAM_WORDS       = 1024,
    parameter string INIT_FILE       = "",
    parameter int    LED_W           = 8,
    parameter int    CLKS_PER_BIT    = 868,
    parameter int    UART_FIFO_DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    soc_mem_io_if.slave      mem,
    output logic [LED_W-1:0] leds_o,
    output logic             uart_tx_o
);

    localparam int AW     = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(UART_FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] IO_LED   = 2'd0;
    localparam logic [1:0] IO_UDATA = 2'd1;
    localparam logic [1:0] IO_USTAT = 2'd2;

    function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                                input logic busy, input logic ovf,
                                                input logic [7:0] cnt);
        return {16'd0, cnt, 4'd0, ovf, busy, empty, full};
    endfunction

    logic [31:0]       ram_r [RAM_WORDS];
    logic [AW-1:0]     ram_idx_s;
    logic              is_io_s;
    logic [1:0]        io_sel_s;
    logic              led_we_s;
    logic              enq_req_s;
    logic              enq_ok_s;
    logic              stat_rd_s;
    logic [31:0]       rdata_s;
    logic [LED_W-1:0]  leds_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_s;
    logic              empty_s;
    logic              ovf_r;
    logic [7:0]        head_s;
    logic              pop_s;
    logic [1:0]        state_r, state_nx;
    logic [BAUD_W-1:0] baud_r, baud_nx;
    logic [2:0]        bit_r, bit_nx;
    logic [7:0]        shift_r, shift_nx;
    logic              tx_r, tx_nx;
    logic              baud_end_s;
    logic              unused_s;

    assign unused_s = ^{mem.mem_addr[30:AW+2], mem.mem_addr[1:0]};

    // Address decode and strobe qualification
    always_comb begin
        is_io_s   = mem.mem_addr[31];
        io_sel_s  = mem.mem_addr[3:2];
        ram_idx_s = mem.mem_addr[AW+1:2];
        led_we_s  = is_io_s && (io_sel_s == IO_LED) && (mem.mem_wmask != 4'd0);
        enq_req_s = is_io_s && (io_sel_s == IO_UDATA) && mem.mem_wmask[0];
        stat_rd_s = is_io_s && (io_sel_s == IO_USTAT) && mem.mem_rstrb;
        enq_ok_s  = enq_req_s && !full_s;
    end

    // Byte-lane RAM write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (!is_io_s) begin
            for (int k = 0; k < 4; k++) begin
                if (mem.mem_wmask[k]) begin
                    ram_r[ram_idx_s][8*k +: 8] <= mem.mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Zero-latency read mux
    always_comb begin
        rdata_s = 32'd0;
        if (!is_io_s) begin
            rdata_s = ram_r[ram_idx_s];
        end else begin
            case (io_sel_s)
                IO_LED:   rdata_s = 32'(leds_r);
                IO_USTAT: rdata_s = pack_status(full_s, empty_s, (state_r != ST_IDLE),
                                                ovf_r, 8'(count_r));
                default:  rdata_s = 32'd0;
            endcase
        end
    end

    assign mem.mem_rdata = rdata_s;

    // LED register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            leds_r <= '0;
        end else if (led_we_s) begin
            leds_r <= mem.mem_wdata[LED_W-1:0];
        end else begin
            leds_r <= leds_r;
        end
    end

`ifdef SOC_UART_FIFO_EN
    localparam int PW = $clog2(UART_FIFO_DEPTH);

    logic [7:0]    fifo_r [UART_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;

    // Circular TX FIFO storage and pointers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (enq_ok_s) begin
                fifo_r[wr_ptr_r] <= mem.mem_wdata[7:0];
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    assign head_s = fifo_r[rd_ptr_r];
    assign full_s = (count_r == CNT_W'(UART_FIFO_DEPTH));
`else
    logic [7:0] hold_r;

    // Single-entry TX holding register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_r <= 8'd0;
        end else if (enq_ok_s) begin
            hold_r <= mem.mem_wdata[7:0];
        end else begin
            hold_r <= hold_r;
        end
    end

    assign head_s = hold_r;
    assign full_s = (count_r == CNT_W'(1));
`endif

    assign empty_s = (count_r == CNT_W'(0));

    // Occupancy and sticky overflow; a new overflow beats the status-read clear
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            case ({enq_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (enq_req_s && full_s) begin
                ovf_r <= 1'b1;
            end else if (stat_rd_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign baud_end_s = (baud_r == BAUD_W'(CLKS_PER_BIT - 1));

    // Transmitter next-state; tx_nx is the line level belonging to the next state
    always_comb begin
        state_nx = state_r;
        baud_nx  = baud_r;
        bit_nx   = bit_r;
        shift_nx = shift_r;
        pop_s    = 1'b0;
        tx_nx    = 1'b1;
        case (state_r)
            ST_IDLE: begin
                baud_nx = '0;
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    shift_nx = head_s;
                    state_nx = ST_START;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_nx  = '0;
                    state_nx = ST_DATA;
                end else begin
                    baud_nx = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_nx  = '0;
                    shift_nx = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        bit_nx   = 3'd0;
                        state_nx = ST_STOP;
                    end else begin
                        bit_nx = bit_r + 3'd1;
                    end
                end else begin
                    baud_nx = baud_r + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_nx = '0;
                    if (!empty_s) begin
                        pop_s    = 1'b1;
                        shift_nx = head_s;
                        state_nx = ST_START;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    baud_nx = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                baud_nx  = '0;
                bit_nx   = 3'd0;
            end
        endcase
        case (state_nx)
            ST_START: tx_nx = 1'b0;
            ST_DATA:  tx_nx = shift_nx[0];
            default:  tx_nx = 1'b1;
        endcase
    end

    // Transmitter state registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_nx;
            baud_r  <= baud_nx;
            bit_r   <= bit_nx;
            shift_r <= shift_nx;
            tx_r    <= tx_nx;
        end
    end

    assign leds_o    = leds_r;
    assign uart_tx_o = tx_r;

endmodule

// File: tb/tb_soc_mem_io.sv
// Directed bench for soc_mem_io: RAM, LED, UART framing, buffer overflow and mid-frame reset.
module tb_soc_mem_io;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_LED   = 32'h8000_0000;
    localparam logic [31:0] A_UDATA = 32'h8000_0004;
    localparam logic [31:0] A_USTAT = 32'h8000_0008;
    localparam logic [31:0] A_RSVD  = 32'h8000_000C;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] leds;
    logic       tx;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       tx_hist [4096];

    soc_mem_io_if bus ();

    soc_mem_io #(
        .RAM_WORDS(1024), .INIT_FILE(""), .LED_W(8),
        .CLKS_PER_BIT(CPB), .UART_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mem(bus), .leds_o(leds), .uart_tx_o(tx)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (cyc < 4096) tx_hist[cyc] <= tx;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.mem_addr  = 32'd0;
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = 4'd0;
        bus.mem_wdata = 32'd0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        bus.mem_addr  = a;
        bus.mem_wmask = m;
        bus.mem_wdata = d;
        step(1);
        bus_idle();
    endtask

    task automatic read(input logic [31:0] a, input logic strobe, output logic [31:0] d);
        bus.mem_addr  = a;
        bus.mem_rstrb = strobe;
        #1;
        d = bus.mem_rdata;
        step(1);
        bus_idle();
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.mem_addr = a;
        #1;
        d = bus.mem_rdata;
        bus.mem_addr = 32'd0;
    endtask

    function automatic logic [39:0] frame_exp(input logic [7:0] b);
        logic [39:0] f;
        for (int i = 0; i < 40; i++) begin
            if (i < CPB)            f[i] = 1'b0;
            else if (i < 9 * CPB)   f[i] = b[(i - CPB) / CPB];
            else                    f[i] = 1'b1;
        end
        return f;
    endfunction

    task automatic check_frame(input string tag, input int start, input logic [7:0] b);
        logic [39:0] g;
        for (int i = 0; i < 40; i++) g[i] = tx_hist[start + i];
        check_eq(tag, 64'(g), 64'(frame_exp(b)));
    endtask

    initial begin
        logic [31:0] d;
        int t;
        logic ones;

        rst_ni = 1'b0;
        bus_idle();
        step(2);
        rst_ni = 1'b1;
        check_eq("rst_leds", 64'(leds), 64'h0);
        check_eq("rst_tx", 64'(tx), 64'h1);
        peek(A_USTAT, d);
        check_eq("rst_status", 64'(d), 64'h2);

        write(32'h0000_0004, 4'hF, 32'h1122_3344);
        write(32'h0000_0006, 4'b0100, 32'h00AB_0000);
        read(32'h0000_0004, 1'b1, d);
        check_eq("ram_byte2", 64'(d), 64'h11AB_3344);
        read(32'h0000_1004, 1'b1, d);
        check_eq("ram_alias", 64'(d), 64'h11AB_3344);
        write(32'h0000_0008, 4'hF, 32'hDEAD_BEEF);
        read(32'h0000_0008, 1'b0, d);
        check_eq("ram_word", 64'(d), 64'hDEAD_BEEF);

        write(A_LED, 4'b1000, 32'h1234_56A5);
        check_eq("led_out", 64'(leds), 64'hA5);
        read(A_LED, 1'b1, d);
        check_eq("led_read", 64'(d), 64'hA5);
        write(A_RSVD, 4'hF, 32'hFFFF_FFFF);
        read(A_RSVD, 1'b1, d);
        check_eq("rsvd_read", 64'(d), 64'h0);
        read(A_UDATA, 1'b1, d);
        check_eq("udata_read", 64'(d), 64'h0);

        // Single frame of 0x55
        t = cyc;
        write(A_UDATA, 4'b0001, 32'h0000_0055);
        peek(A_USTAT, d);
`ifdef SOC_UART_FIFO_EN
        check_eq("stat_t1", 64'(d), 64'h100);
`else
        check_eq("stat_t1", 64'(d), 64'h101);
`endif
        step(40);
        peek(A_USTAT, d);
        check_eq("busy_t41", 64'(d[2]), 64'h1);
        step(1);
        peek(A_USTAT, d);
        check_eq("busy_t42", 64'(d[2]), 64'h0);
        step(2);
        check_eq("idle_t1", 64'(tx_hist[t + 1]), 64'h1);
        check_frame("frame_55", t + 2, 8'h55);
        check_eq("idle_t42", 64'(tx_hist[t + 42]), 64'h1);

`ifdef SOC_UART_FIFO_EN
        t = cyc;
        for (int i = 0; i < 6; i++) write(A_UDATA, 4'b0001, 32'(i + 1));
        read(A_USTAT, 1'b1, d);
        check_eq("fifo_full_ovf", 64'(d), 64'h40D);
        peek(A_USTAT, d);
        check_eq("fifo_ovf_clr", 64'(d), 64'h405);
        step(199);
        for (int k = 0; k < 5; k++) check_frame($sformatf("fifo_frame%0d", k + 1), t + 2 + 40 * k, 8'(k + 1));
        check_eq("fifo_idle", 64'(tx_hist[t + 202]), 64'h1);
        peek(A_USTAT, d);
        check_eq("fifo_empty", 64'(d), 64'h2);
`else
        t = cyc;
        write(A_UDATA, 4'b0001, 32'h0000_00A3);
        write(A_UDATA, 4'b0001, 32'h0000_003C);
        write(A_UDATA, 4'b0001, 32'h0000_003C);
        read(A_USTAT, 1'b1, d);
        check_eq("hold_full_ovf", 64'(d), 64'h10D);
        peek(A_USTAT, d);
        check_eq("hold_ovf_clr", 64'(d), 64'h105);
        step(80);
        check_frame("hold_frameA", t + 2, 8'hA3);
        check_frame("hold_frameB", t + 42, 8'h3C);
        check_eq("hold_idle", 64'(tx_hist[t + 82]), 64'h1);
        peek(A_USTAT, d);
        check_eq("hold_empty", 64'(d), 64'h2);
`endif

        // Reset during DATA bit 3 with a byte still queued
        t = cyc;
        write(A_UDATA, 4'b0001, 32'h0000_00A5);
        step(2);
        write(A_UDATA, 4'b0001, 32'h0000_0077);
        step(15);
        check_eq("bit3_level", 64'(tx), 64'h0);
        rst_ni = 1'b0;
        step(1);
        rst_ni = 1'b1;
        check_eq("abort_tx", 64'(tx), 64'h1);
        check_eq("abort_leds", 64'(leds), 64'h0);
        peek(A_USTAT, d);
        check_eq("abort_status", 64'(d), 64'h2);
        step(60);
        ones = 1'b1;
        for (int i = 20; i < 80; i++) ones = ones & tx_hist[t + i];
        check_eq("no_frame_after_rst", 64'(ones), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
